regfile_wb_scheduler: RTL

//  Sequences the register file's single write port and tracks pending destination registers.

---
 rtl/regfile_wb_scheduler_pkg.sv | 15 +
 rtl/regfile_wb_scheduler_if.sv | 28 ++
 rtl/regfile_wb_scheduler_chk.sv | 27 ++
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 52 +++++
 rtl/regfile_wb_scheduler.sv | 115 +++++++++++
 5 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file constants and writeback types for the writeback scheduler slice.
package regfile_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback requester handshake plus register-file write port, grouped for the scheduler.
interface regfile_wb_scheduler_if
  import regfile_pkg::*;
#(
  parameter int NR = 2,
  parameter int AW = ADDR_WIDTH,
  parameter int DW = DATA_WIDTH
);

  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_data;
  logic                  rf_write_enable;
  logic [AW-1:0]         rf_write_addr;
  logic [DW-1:0]         rf_write_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_write_enable, rf_write_addr, rf_write_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_write_enable, rf_write_addr, rf_write_data
  );

endinterface

// File: rtl/regfile_wb_scheduler_chk.sv
// Protocol and invariant assertions for the writeback scheduler.
module regfile_wb_scheduler_chk #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic                                  clk,
  input logic                                  rst,
  input logic [NUM_REQ-1:0]                    req_valid,
  input logic [NUM_REQ-1:0]                    req_ready,
  input logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
  input logic [(2**ADDR_WIDTH)-1:0]            busy_mask
);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_addr[i]) && $stable(req_data[i])));
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_ready_valid: assert property (@(posedge clk) disable iff (rst)
    (req_ready & ~req_valid) == '0);
  a_x0_clear: assert property (@(posedge clk) disable iff (rst) !busy_mask[0]);

endmodule

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from a rotating pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] nxt_s;
  logic [PW:0]   cand_s;
  logic          found_s;

  // Search from the pointer; the winner's successor becomes the next start point.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    nxt_s   = ptr_q;
    cand_s  = '0;
    for (int off = 0; off < N; off++) begin
      cand_s = {1'b0, ptr_q} + (PW+1)'(off);
      if (cand_s >= (PW+1)'(N)) begin
        cand_s = cand_s - (PW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[PW-1:0]]) begin
        found_s                = 1'b1;
        grant[cand_s[PW-1:0]] = 1'b1;
        nxt_s = (cand_s[PW-1:0] == PW'(N - 1)) ? '0 : cand_s[PW-1:0] + PW'(1);
      end else begin
        found_s = found_s;
      end
    end
    ptr_d = (found_s && advance) ? nxt_s : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback onto a single registered register-file write port,
// with a busy-bit scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  regfile_wb_scheduler_if.slave         wb,
  input  logic                          issue_valid,
  input  logic                          issue_rd_valid,
  input  logic [ADDR_WIDTH-1:0]         issue_rd,
  input  logic [ADDR_WIDTH-1:0]         issue_rs1,
  input  logic [ADDR_WIDTH-1:0]         issue_rs2,
  output logic                          issue_stall,
  output logic [(2**ADDR_WIDTH)-1:0]    busy_mask
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_REQ-1:0]    grant_s;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  issue_fire_s;
  logic [NUM_REGS-1:0]   clr_mask_s, set_mask_s;

  logic                  we_d, we_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic [NUM_REGS-1:0]   busy_d, busy_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wb.req_valid),
    .advance (1'b1),
    .grant   (grant_s)
  );

  // No transfer may be acknowledged while reset is held.
  assign wb.req_ready = rst ? '0 : grant_s;
  assign xfer_s       = |wb.req_ready;

  // Grant is one-hot, so an OR of masked requests selects the winner.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_WIDTH{wb.req_ready[i]}} & wb.req_addr[i]);
      sel_data_s = sel_data_s | ({DATA_WIDTH{wb.req_ready[i]}} & wb.req_data[i]);
    end
  end

  // Writes to x0 are accepted but dropped; addr/data hold when nothing is written.
  always_comb begin
    we_d = xfer_s && (sel_addr_s != '0);
    if (we_d) begin
      addr_d = sel_addr_s;
      data_d = sel_data_s;
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  assign issue_stall = issue_valid &&
                       (busy_q[issue_rs1] || busy_q[issue_rs2] ||
                        (issue_rd_valid && busy_q[issue_rd]));
  assign issue_fire_s = issue_valid && issue_rd_valid && !issue_stall &&
                        (issue_rd != '0);

  // Clear lands on the same edge the register file writes; a concurrent set wins.
  always_comb begin
    clr_mask_s = we_q ? (NUM_REGS'(1) << addr_q) : '0;
    set_mask_s = issue_fire_s ? (NUM_REGS'(1) << issue_rd) : '0;
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~NUM_REGS'(1);
  end

  // Output write port and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign wb.rf_write_enable = we_q;
  assign wb.rf_write_addr   = addr_q;
  assign wb.rf_write_data   = data_q;
  assign busy_mask          = busy_q;

  regfile_wb_scheduler_chk #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_valid (wb.req_valid),
    .req_ready (wb.req_ready),
    .req_addr  (wb.req_addr),
    .req_data  (wb.req_data),
    .busy_mask (busy_q)
  );

endmodule
